// File: rtl/nios2_pio_pkg.sv
// Shared register map, pulse FSM encoding and STATUS layout for the RF control PIO.
package nios2_pio_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN  = 3'd1;
  localparam logic [2:0] ADDR_PULSE_TRIG = 3'd2;
  localparam logic [2:0] ADDR_STATUS     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET     = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;
  localparam logic [2:0] ADDR_IRQ_EN     = 3'd6;
  localparam logic [2:0] ADDR_DONE       = 3'd7;

  localparam int STATUS_BUSY_BIT = 31;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PULSING = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/nios2_pio_pulse_timer.sv
// One-shot pulse timer: tracks which DATA bits are pulsing and counts down their lifetime.
module nios2_pio_pulse_timer
  import nios2_pio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trig,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] mask,
  output logic             accept,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             expire,
  output logic [WIDTH-1:0] pmask
);

  pulse_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;

  // Zero length or zero mask triggers are dropped in either state.
  assign accept = trig && (len != '0) && (mask != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pmask_d = pmask_q;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_PULSING;
          cnt_d   = len;
          pmask_d = mask;
        end
      end
      ST_PULSING: begin
        // A retrigger landing on the final cycle extends the pulse instead of expiring it.
        if (accept) begin
          cnt_d   = len;
          pmask_d = pmask_q | mask;
        end else if (cnt_q == CNT_W'(1)) begin
          expire  = 1'b1;
          cnt_d   = '0;
          pmask_d = '0;
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pmask_q <= pmask_d;
    end
  end

  assign busy  = (state_q == ST_PULSING);
  assign count = cnt_q;
  assign pmask = pmask_q;

endmodule

// File: rtl/nios2_rf_ctrl_pio.sv
// Avalon-MM output PIO with atomic set/clear, one-shot pulse timer and pulse-done IRQ.
module nios2_rf_ctrl_pio
  import nios2_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             t_accept, t_busy, t_expire;
  logic [CNT_W-1:0] t_count;
  logic [WIDTH-1:0] t_pmask;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  nios2_pio_pulse_timer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .trig    (wr && (address == ADDR_PULSE_TRIG)),
    .len     (len_q),
    .mask    (wd),
    .accept  (t_accept),
    .busy    (t_busy),
    .count   (t_count),
    .expire  (t_expire),
    .pmask   (t_pmask)
  );

  // Expiry clears first so a bus write on the same edge wins bit-by-bit.
  always_comb begin
    data_d   = data_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    if (t_expire) data_d = data_d & ~t_pmask;
    if (wr) begin
      case (address)
        ADDR_DATA:       data_d   = wd;
        ADDR_PULSE_LEN:  len_d    = writedata[CNT_W-1:0];
        ADDR_PULSE_TRIG: if (t_accept) data_d = data_d | wd;
        ADDR_OUTSET:     data_d   = data_d | wd;
        ADDR_OUTCLEAR:   data_d   = data_d & ~wd;
        ADDR_IRQ_EN:     irq_en_d = writedata[0];
        ADDR_DONE:       if (writedata[0]) done_d = 1'b0;
        default: ;
      endcase
    end
    if (t_expire) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      len_q    <= len_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(data_q);
      ADDR_PULSE_LEN: readdata = 32'(len_q);
      ADDR_STATUS: begin
        readdata                  = 32'(t_count);
        readdata[STATUS_BUSY_BIT] = t_busy;
      end
      ADDR_IRQ_EN:    readdata = {31'd0, irq_en_q};
      ADDR_DONE:      readdata = {31'd0, done_q};
      default:        readdata = '0;
    endcase
  end

  assign out_port = data_q;
  assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_nios2_rf_ctrl_pio.sv
// Bench for nios2_rf_ctrl_pio: register vector table plus hand-built pulse-timer sequences.
module tb_nios2_rf_ctrl_pio;
  import nios2_pio_pkg::*;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 16;
  localparam logic [7:0] RV    = 8'hA5;
  localparam logic [31:0] BUSY = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  nios2_rf_ctrl_pio #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VALUE(RV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [2:0]  a;
    logic [31:0] wd;
    logic [7:0]  out;
    logic [2:0]  ra;
    logic [31:0] rd;
  } vec_t;
  vec_t vt[13];

  int checks   = 0;
  int failures = 0;

  task automatic expq(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic got(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = sbq.pop_front();
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s actual=%h expected=%h", e.name, act, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic chk_rd(input string n, input logic [2:0] a, input logic [31:0] v);
    logic [31:0] d;
    expq(n, v);
    rd(a, d);
    got(d);
  endtask

  task automatic chk_out(input string n, input logic [7:0] v);
    expq(n, 32'(v));
    got(32'(out_port));
  endtask

  task automatic chk_irq(input string n, input logic v);
    expq(n, 32'(v));
    got(32'(irq));
  endtask

  initial begin
    vt[0]  = '{ADDR_DATA,       32'h0F,      8'h0F, ADDR_DATA,       32'h0F};
    vt[1]  = '{ADDR_OUTSET,     32'h30,      8'h3F, ADDR_DATA,       32'h3F};
    vt[2]  = '{ADDR_OUTCLEAR,   32'h01,      8'h3E, ADDR_DATA,       32'h3E};
    vt[3]  = '{ADDR_OUTSET,     32'h00,      8'h3E, ADDR_OUTSET,     32'h0};
    vt[4]  = '{ADDR_OUTCLEAR,   32'h00,      8'h3E, ADDR_PULSE_TRIG, 32'h0};
    vt[5]  = '{ADDR_DATA,       32'h1FF,     8'hFF, ADDR_DATA,       32'hFF};
    vt[6]  = '{ADDR_OUTCLEAR,   32'hAA,      8'h55, ADDR_OUTCLEAR,   32'h0};
    vt[7]  = '{ADDR_PULSE_LEN,  32'h12345,   8'h55, ADDR_PULSE_LEN,  32'h2345};
    vt[8]  = '{ADDR_PULSE_LEN,  32'h0,       8'h55, ADDR_PULSE_LEN,  32'h0};
    vt[9]  = '{ADDR_PULSE_TRIG, 32'hFF,      8'h55, ADDR_STATUS,     32'h0};
    vt[10] = '{ADDR_IRQ_EN,     32'h3,       8'h55, ADDR_IRQ_EN,     32'h1};
    vt[11] = '{ADDR_IRQ_EN,     32'h0,       8'h55, ADDR_IRQ_EN,     32'h0};
    vt[12] = '{ADDR_DONE,       32'h1,       8'h55, ADDR_DONE,       32'h0};

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);

    // Reset state
    chk_out("rst_out", RV);
    chk_rd("rst_data", ADDR_DATA, 32'(RV));
    chk_irq("rst_irq", 1'b0);
    chk_rd("rst_status", ADDR_STATUS, 32'h0);
    chk_rd("rst_len", ADDR_PULSE_LEN, 32'h0);
    chk_rd("rst_done", ADDR_DONE, 32'h0);

    // Register table
    for (int i = 0; i < 13; i++) begin
      expq($sformatf("vec%0d_out", i), 32'(vt[i].out));
      wr(vt[i].a, vt[i].wd);
      got(32'(out_port));
      chk_rd($sformatf("vec%0d_rd", i), vt[i].ra, vt[i].rd);
    end

    // Single pulse on bit7 with IRQ
    wr(ADDR_DATA, 32'h0);
    wr(ADDR_PULSE_LEN, 32'd5);
    wr(ADDR_IRQ_EN, 32'h1);
    wr(ADDR_PULSE_TRIG, 32'h80);
    chk_out("p1_start_out", 8'h80);
    chk_rd("p1_start_status", ADDR_STATUS, BUSY | 32'd5);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (k < 5) begin
        chk_out($sformatf("p1_c%0d_out", k), 8'h80);
        chk_rd($sformatf("p1_c%0d_status", k), ADDR_STATUS, BUSY | 32'(5 - k));
        chk_irq($sformatf("p1_c%0d_irq", k), 1'b0);
      end else begin
        chk_out("p1_end_out", 8'h00);
        chk_rd("p1_end_status", ADDR_STATUS, 32'h0);
        chk_rd("p1_end_done", ADDR_DONE, 32'h1);
        chk_irq("p1_end_irq", 1'b1);
      end
    end
    wr(ADDR_DONE, 32'h1);
    chk_irq("p1_w1c_irq", 1'b0);
    chk_rd("p1_w1c_done", ADDR_DONE, 32'h0);

    // Retrigger extends both bits, single DONE
    wr(ADDR_PULSE_LEN, 32'd10);
    wr(ADDR_PULSE_TRIG, 32'h01);
    tick(3);
    chk_rd("rt_c3_status", ADDR_STATUS, BUSY | 32'd7);
    wr(ADDR_PULSE_TRIG, 32'h02);
    chk_out("rt_out", 8'h03);
    chk_rd("rt_status", ADDR_STATUS, BUSY | 32'd10);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 9) begin
        chk_out("rt_c9_out", 8'h03);
        chk_rd("rt_c9_done", ADDR_DONE, 32'h0);
      end else if (k == 10) begin
        chk_out("rt_c10_out", 8'h00);
        chk_rd("rt_c10_done", ADDR_DONE, 32'h1);
        chk_rd("rt_c10_status", ADDR_STATUS, 32'h0);
      end
    end
    tick(12);
    wr(ADDR_DONE, 32'h1);
    tick(3);
    chk_rd("rt_single_done", ADDR_DONE, 32'h0);

    // Bus set wins over expiry clear on the same edge
    wr(ADDR_PULSE_LEN, 32'd3);
    wr(ADDR_PULSE_TRIG, 32'h81);
    tick(2);
    wr(ADDR_OUTSET, 32'h80);
    chk_out("exp_set_out", 8'h80);
    chk_rd("exp_set_status", ADDR_STATUS, 32'h0);
    chk_rd("exp_set_done", ADDR_DONE, 32'h1);

    // Retrigger on the expiry cycle stays pulsing
    wr(ADDR_DONE, 32'h1);
    wr(ADDR_PULSE_TRIG, 32'h04);
    chk_out("rte_start_out", 8'h84);
    tick(2);
    wr(ADDR_PULSE_TRIG, 32'h08);
    chk_out("rte_out", 8'h8C);
    chk_rd("rte_status", ADDR_STATUS, BUSY | 32'd3);
    chk_rd("rte_done", ADDR_DONE, 32'h0);
    tick(3);
    chk_out("rte_end_out", 8'h80);
    chk_rd("rte_end_done", ADDR_DONE, 32'h1);

    // DONE set beats W1C on the same edge
    wr(ADDR_PULSE_LEN, 32'd2);
    wr(ADDR_PULSE_TRIG, 32'h01);
    tick(1);
    wr(ADDR_DONE, 32'h1);
    chk_rd("setwin_done", ADDR_DONE, 32'h1);
    chk_out("setwin_out", 8'h80);

    // PULSE_LEN change mid-pulse affects only the next trigger
    wr(ADDR_PULSE_LEN, 32'd4);
    wr(ADDR_PULSE_TRIG, 32'h02);
    wr(ADDR_PULSE_LEN, 32'd20);
    chk_rd("lenchg_status", ADDR_STATUS, BUSY | 32'd3);
    tick(3);
    chk_out("lenchg_out", 8'h80);
    chk_rd("lenchg_end_status", ADDR_STATUS, 32'h0);

    // Asynchronous reset mid-pulse
    wr(ADDR_PULSE_LEN, 32'd10);
    wr(ADDR_PULSE_TRIG, 32'h10);
    tick(7);
    chk_rd("mid_status", ADDR_STATUS, BUSY | 32'd3);
    reset_n = 1'b0;
    #1;
    chk_out("arst_out", RV);
    chk_rd("arst_status", ADDR_STATUS, 32'h0);
    chk_rd("arst_done", ADDR_DONE, 32'h0);
    chk_rd("arst_len", ADDR_PULSE_LEN, 32'h0);
    chk_irq("arst_irq", 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);
    chk_out("post_rst_out", RV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
